parity_frame_checker: RTL and testbench

- Serial-frame parity stage that sits downstream of the XOR gate primitives.
- Folds a stream of data bits through a running XOR and latches even/odd parity mode at frame start.
- Compares the computed parity against a trailing received parity bit and reports the result with a one-cycle done/err pulse.
- Keeps running frame and error statistics for the link-checking datapath.

---
 rtl/parity_frame_checker.sv | 158 +++++++++++++++
 tb/tb_parity_frame_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
//   Serial-frame parity checker. A frame is FRAME_LEN data bits followed by
//   one received parity bit. The data bits are folded through a running XOR.
//   The parity mode (even/odd) is captured when the frame starts. The computed
//   parity is compared with the received bit, and the result is reported as a
//   registered one-cycle done/err pulse. Frame and error statistics are kept.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin a frame (honoured only while idle)
//   abort      drop the current frame (honoured while busy)
//   mode_odd   parity mode, 1 = odd, 0 = even (sampled at frame start)
//   bit_in     serial data or parity bit
//   bit_valid  bit_in is valid this cycle
//   busy       a frame is in progress
//   parity_out computed parity of the last completed frame
//   done       one-cycle pulse when a frame completes
//   err        one-cycle pulse with done on a parity mismatch
//   bit_cnt    data bits accepted in the current frame
//   frame_cnt  completed frames, wrapping
//   err_cnt    frames with a parity error, saturating
module parity_frame_checker #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             mode_odd,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             parity_out,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [7:0]       frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN);

  logic [1:0]       state_q, state_d;
  logic             acc_q, acc_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             parity_out_d;
  logic             done_d, err_d;
  logic [7:0]       frame_cnt_d, err_cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             expected;

  assign cnt_inc  = bit_cnt + CNT_W'(1);
  assign expected = acc_q ^ mode_q;
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mode_d       = mode_q;
    bit_cnt_d    = bit_cnt;
    parity_out_d = parity_out;
    done_d       = 1'b0;
    err_d        = 1'b0;
    frame_cnt_d  = frame_cnt;
    err_cnt_d    = err_cnt;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          mode_d    = mode_odd;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
          // A bit presented together with start is data bit 0.
          if (bit_valid) begin
            acc_d     = bit_in;
            bit_cnt_d = CNT_W'(1);
            if (LAST_CNT == CNT_W'(1)) begin
              state_d = CHECK;
            end
          end
        end
      end

      ACCUM: begin
        if (abort) begin
          state_d   = IDLE;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
        end else if (bit_valid) begin
          acc_d     = acc_q ^ bit_in;
          bit_cnt_d = cnt_inc;
          if (cnt_inc == LAST_CNT) begin
            state_d = CHECK;
          end
        end
      end

      CHECK: begin
        // abort wins over the parity bit, so an aborted frame never reports.
        if (abort) begin
          state_d   = IDLE;
          acc_d     = 1'b0;
          bit_cnt_d = '0;
        end else if (bit_valid) begin
          state_d      = IDLE;
          acc_d        = 1'b0;
          bit_cnt_d    = '0;
          done_d       = 1'b1;
          err_d        = (bit_in != expected);
          parity_out_d = expected;
          frame_cnt_d  = frame_cnt + 8'd1;
          if ((bit_in != expected) && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
          end
        end
      end

      default: begin
        state_d   = IDLE;
        acc_d     = 1'b0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= 1'b0;
      mode_q     <= 1'b0;
      bit_cnt    <= '0;
      parity_out <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      frame_cnt  <= 8'd0;
      err_cnt    <= 8'd0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      mode_q     <= mode_d;
      bit_cnt    <= bit_cnt_d;
      parity_out <= parity_out_d;
      done       <= done_d;
      err        <= err_d;
      frame_cnt  <= frame_cnt_d;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb_parity_frame_checker
//   Randomised and directed stimulus for parity_frame_checker with FRAME_LEN=8.
//   A behavioural model collects the data bits of the current frame in a queue
//   and computes parity from them when the parity bit arrives. Every falling
//   edge compares all DUT outputs against the model. Directed frames also check
//   hand-computed literal values.
module tb_parity_frame_checker;

  localparam int unsigned FL = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0, abort = 1'b0, mode_odd = 1'b0;
  logic          bit_in = 1'b0, bit_valid = 1'b0;
  logic          busy, parity_out, done, err;
  logic [CW-1:0] bit_cnt;
  logic [7:0]    frame_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  parity_frame_checker #(.FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_odd(mode_odd),
    .bit_in(bit_in), .bit_valid(bit_valid), .busy(busy), .parity_out(parity_out),
    .done(done), .err(err), .bit_cnt(bit_cnt), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_active = 1'b0;
  bit m_mode   = 1'b0;
  bit m_pout   = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  int m_fc     = 0;
  int m_ec     = 0;
  bit m_q[$];

  function automatic bit xor_all(input bit q[$]);
    bit p = 1'b0;
    foreach (q[i]) p = p ^ q[i];
    return p;
  endfunction

  initial begin
    bit exp_par;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_active = 1'b0; m_mode = 1'b0; m_pout = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_fc = 0; m_ec = 0; m_q.delete();
      end else begin
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!m_active) begin
          if (start) begin
            m_active = 1'b1;
            m_mode   = mode_odd;
            m_q.delete();
            if (bit_valid) m_q.push_back(bit_in);
          end
        end else if (abort) begin
          m_active = 1'b0;
          m_q.delete();
        end else if (bit_valid) begin
          if (m_q.size() < FL) begin
            m_q.push_back(bit_in);
          end else begin
            exp_par = xor_all(m_q) ^ m_mode;
            m_done  = 1'b1;
            m_err   = (bit_in != exp_par);
            m_pout  = exp_par;
            m_fc    = (m_fc + 1) % 256;
            if (m_err && m_ec < 255) m_ec = m_ec + 1;
            m_active = 1'b0;
            m_q.delete();
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all(input string tag);
    chk({tag, ".busy"}, int'(busy), int'(m_active));
    chk({tag, ".done"}, int'(done), int'(m_done));
    chk({tag, ".err"}, int'(err), int'(m_err));
    chk({tag, ".parity_out"}, int'(parity_out), int'(m_pout));
    chk({tag, ".bit_cnt"}, int'(bit_cnt), m_q.size());
    chk({tag, ".frame_cnt"}, int'(frame_cnt), m_fc);
    chk({tag, ".err_cnt"}, int'(err_cnt), m_ec);
  endtask

  bit cmp_en = 1'b0;
  initial forever begin
    @(negedge clk);
    if (cmp_en) cmp_all("cyc");
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit s, input bit a, input bit m, input bit v, input bit b);
    @(negedge clk);
    start = s; abort = a; mode_odd = m; bit_valid = v; bit_in = b;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0);
  endtask

  // d[0] is the first data bit on the line. Returns at the falling edge where
  // the result of the parity bit is visible.
  task automatic send_frame(input bit mode, input logic [7:0] d, input bit par,
                            input int gap, input bit restart);
    drive(1, 0, mode, 1, d[0]);
    for (int i = 1; i <= 8; i++) begin
      for (int g = 0; g < gap; g++) begin
        drive(0, 0, 0, 0, 0);
        if (g == 0) chk("gap.bit_cnt", int'(bit_cnt), i);
      end
      if (i < 8) drive(restart && i == 4, 0, ~mode, 1, d[i]);
      else       drive(0, 0, ~mode, 1, par);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic check_result(input string tag, input bit e_err, input bit e_par,
                              input int e_fc, input int e_ec);
    chk({tag, ".done"}, int'(done), 1);
    chk({tag, ".err"}, int'(err), int'(e_err));
    chk({tag, ".parity_out"}, int'(parity_out), int'(e_par));
    chk({tag, ".frame_cnt"}, int'(frame_cnt), e_fc);
    chk({tag, ".err_cnt"}, int'(err_cnt), e_ec);
    chk({tag, ".busy"}, int'(busy), 0);
    chk({tag, ".model_fc"}, m_fc, e_fc);
    chk({tag, ".model_ec"}, m_ec, e_ec);
  endtask

  initial begin
    logic [7:0] dat;
    dat = 8'b0100_1101;  // line order 1,0,1,1,0,0,1,0

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    idle(5);
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.err", int'(err), 0);
    chk("rst.parity_out", int'(parity_out), 0);
    chk("rst.bit_cnt", int'(bit_cnt), 0);
    chk("rst.frame_cnt", int'(frame_cnt), 0);
    chk("rst.err_cnt", int'(err_cnt), 0);

    send_frame(0, dat, 0, 0, 0);
    check_result("even", 0, 0, 1, 0);
    send_frame(1, dat, 0, 0, 0);
    check_result("odd", 1, 1, 2, 1);
    idle(1);
    chk("pulse.done", int'(done), 0);
    chk("hold.parity_out", int'(parity_out), 1);
    send_frame(0, dat, 0, 3, 1);
    check_result("gap", 0, 0, 3, 1);

    // Abort after 5 data bits.
    drive(1, 0, 0, 1, dat[0]);
    for (int i = 1; i < 5; i++) drive(0, 0, 0, 1, dat[i]);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.bit_cnt", int'(bit_cnt), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.frame_cnt", int'(frame_cnt), 3);
    chk("abort.err_cnt", int'(err_cnt), 1);

    // Abort together with the parity bit.
    drive(1, 0, 0, 1, 1'b1);
    for (int i = 1; i < 8; i++) drive(0, 0, 0, 1, 1'b1);
    drive(0, 1, 0, 1, 1'b1);
    drive(0, 0, 0, 0, 0);
    chk("abortchk.done", int'(done), 0);
    chk("abortchk.frame_cnt", int'(frame_cnt), 3);

    send_frame(0, 8'hFF, 0, 0, 0);
    check_result("ones", 0, 0, 4, 1);

    // Asynchronous reset mid-frame.
    drive(1, 0, 0, 1, 1'b1);
    drive(0, 0, 0, 1, 1'b0);
    drive(0, 0, 0, 1, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.bit_cnt", int'(bit_cnt), 0);
    chk("arst.frame_cnt", int'(frame_cnt), 0);
    chk("arst.err_cnt", int'(err_cnt), 0);
    cmp_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Counter limits: every frame carries a wrong parity bit.
    for (int f = 0; f < 258; f++) begin
      logic [7:0] d;
      bit m;
      d = 8'($urandom);
      m = 1'($urandom);
      send_frame(m, d, ~((^d) ^ m), 0, 0);
      chk("sat.err", int'(err), 1);
      if (f == 255) begin
        chk("wrap.frame_cnt", int'(frame_cnt), 0);
        chk("wrap.err_cnt", int'(err_cnt), 255);
      end
    end
    chk("sat.frame_cnt", int'(frame_cnt), 2);
    chk("sat.err_cnt", int'(err_cnt), 255);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), 1'($urandom),
            ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
